// File: rtl/act_packer_pkg.sv
// rtl/act_packer_pkg.sv - shared widths, FIFO entry type and requantization helpers
package act_packer_pkg;

   localparam int IN_W       = 21;
   localparam int OUT_W      = 8;
   localparam int LANES      = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int LANE_W     = $clog2(LANES);

   typedef struct packed {
      logic [LANES*OUT_W-1:0] data;
      logic [LANES-1:0]       keep;
      logic                   last;
   } fifo_entry_t;

   // Right shift with round-half-to-even; result stays IN_W wide so saturation can see overflow.
   function automatic logic [IN_W-1:0] round_shift(input logic [IN_W-1:0] d, input logic [3:0] s);
      logic [IN_W-1:0] q0;
      logic [IN_W-1:0] mask;
      logic            g;
      logic            r;
      logic            st;
      logic [IN_W-1:0] res;
      if (s == 4'd0) begin
         res = d;
      end else begin
         q0   = d >> s;
         g    = d[s];
         r    = d[s - 4'd1];
         mask = (IN_W'(1) << (s - 4'd1)) - IN_W'(1);
         st   = |(d & mask);
         res  = q0 + IN_W'(r && (st || g));
      end
      return res;
   endfunction

   function automatic logic [OUT_W-1:0] saturate(input logic [IN_W-1:0] q);
      return (q > IN_W'(255)) ? {OUT_W{1'b1}} : q[OUT_W-1:0];
   endfunction

   function automatic logic [OUT_W-1:0] requantize(input logic [IN_W-1:0] d, input logic [3:0] s);
      return saturate(round_shift(d, s));
   endfunction

endpackage

// File: rtl/act_packer_if.sv
// rtl/act_packer_if.sv - activation input stream and packed-word output stream
interface act_packer_if;

   logic                                                    i_valid;
   logic                                                    i_ready;
   logic [act_packer_pkg::IN_W-1:0]                         i_data;
   logic                                                    i_last;
   logic [3:0]                                              i_shift;
   logic                                                    o_valid;
   logic                                                    o_ready;
   logic [act_packer_pkg::LANES*act_packer_pkg::OUT_W-1:0]  o_data;
   logic [act_packer_pkg::LANES-1:0]                        o_keep;
   logic                                                    o_last;

   modport slave (
      input  i_valid, i_data, i_last, i_shift, o_ready,
      output i_ready, o_valid, o_data, o_keep, o_last
   );

   modport master (
      output i_valid, i_data, i_last, i_shift, o_ready,
      input  i_ready, o_valid, o_data, o_keep, o_last
   );

endinterface

// File: rtl/act_packer_fifo.sv
// rtl/act_packer_fifo.sv - generic synchronous FIFO, power-of-two depth, head shown on rdata
module act_packer_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage is reset so the head reads as zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/act_packer.sv
// rtl/act_packer.sv - requantize/saturate activations, pack LANES per word, buffer in FIFO
// Optional saturation counter port o_sat_cnt when ACT_PACKER_STATS_EN is defined.
module act_packer
   import act_packer_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   act_packer_if.slave   bus
`ifdef ACT_PACKER_STATS_EN
   ,
   output logic [15:0]   o_sat_cnt
`endif
);

   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {
      FILL,
      LAST_LANE
   } state_t;

   state_t                 state;
   logic [LANE_W-1:0]      lane;
   logic [LANES*OUT_W-1:0] asm_data;
   logic [LANES-1:0]       asm_keep;

   logic                   accept;
   logic                   complete;
   logic [IN_W-1:0]        q;
   logic [OUT_W-1:0]       lane_val;
   fifo_entry_t            push_entry;
   fifo_entry_t            head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CW-1:0]          fifo_count;

   assign bus.i_ready = (fifo_count < CW'(DEPTH));
   assign accept      = bus.i_valid && bus.i_ready;
   assign q           = round_shift(bus.i_data, bus.i_shift);
   assign lane_val    = saturate(q);
   assign complete    = accept && ((state == LAST_LANE) || bus.i_last);

   // The word pushed on completion already includes the lane being accepted this cycle.
   always_comb begin
      push_entry                              = '0;
      push_entry.data                         = asm_data;
      push_entry.data[lane*OUT_W +: OUT_W]    = lane_val;
      push_entry.keep                         = asm_keep;
      push_entry.keep[lane]                   = 1'b1;
      push_entry.last                         = bus.i_last;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FILL;
         lane     <= '0;
         asm_data <= '0;
         asm_keep <= '0;
      end else if (accept) begin
         if (complete) begin
            state    <= FILL;
            lane     <= '0;
            asm_data <= '0;
            asm_keep <= '0;
         end else begin
            state    <= (lane == LANE_W'(LANES - 2)) ? LAST_LANE : FILL;
            lane     <= lane + LANE_W'(1);
            asm_data <= push_entry.data;
            asm_keep <= push_entry.keep;
         end
      end
   end

   act_packer_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (complete && !fifo_full),
      .pop   (bus.o_ready),
      .wdata (push_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.o_valid = !fifo_empty;
   assign bus.o_data  = head.data;
   assign bus.o_keep  = head.keep;
   assign bus.o_last  = head.last;

`ifdef ACT_PACKER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_sat_cnt <= '0;
      end else if (accept && (q > IN_W'(255)) && (o_sat_cnt != 16'hFFFF)) begin
         o_sat_cnt <= o_sat_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_act_packer.sv
// tb/tb_act_packer.sv - scoreboard bench for act_packer
module tb_act_packer;
   import act_packer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   act_packer_if bus();

`ifdef ACT_PACKER_STATS_EN
   logic [15:0] sat_cnt;
`endif

   act_packer dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus)
`ifdef ACT_PACKER_STATS_EN
      ,
      .o_sat_cnt (sat_cnt)
`endif
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   fifo_entry_t exp_q[$];
   int          m_lane   = 0;
   logic [31:0] m_data   = '0;
   logic [3:0]  m_keep   = '0;
   int          m_sat    = 0;
   logic [31:0] last_data;
   logic [3:0]  last_keep;
   logic        last_last;
   int          n_pops   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Unclamped reference: integer divide, round half to even on the remainder.
   function automatic int unsigned ref_q(input int unsigned d, input int unsigned s);
      int unsigned q, rem, half;
      if (s == 0) return d;
      q    = d >> s;
      rem  = d & ((32'd1 << s) - 1);
      half = 32'd1 << (s - 1);
      if (rem > half || (rem == half && q[0])) q++;
      return q;
   endfunction

   task automatic model_accept(input int unsigned d, input int unsigned s, input bit last);
      int unsigned q;
      fifo_entry_t e;
      q = ref_q(d, s);
      if (q > 255) begin
         m_sat++;
         q = 255;
      end
      m_data[m_lane*8 +: 8] = q[7:0];
      m_keep[m_lane]        = 1'b1;
      if (m_lane == 3 || last) begin
         e.data = m_data;
         e.keep = m_keep;
         e.last = last;
         exp_q.push_back(e);
         m_lane = 0;
         m_data = '0;
         m_keep = '0;
      end else begin
         m_lane++;
      end
   endtask

   task automatic model_reset();
      m_lane = 0;
      m_data = '0;
      m_keep = '0;
      m_sat  = 0;
      exp_q.delete();
   endtask

   // Called at a falling edge; i_ready is stable there and decides the next rising edge.
   task automatic try_send(input int unsigned d, input int unsigned s, input bit last, output bit acc);
      bus.i_data  = d[20:0];
      bus.i_shift = s[3:0];
      bus.i_last  = last;
      bus.i_valid = 1'b1;
      acc = bus.i_ready;
      @(posedge clk);
      if (acc) model_accept(d, s, last);
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
   endtask

   task automatic send(input int unsigned d, input int unsigned s, input bit last);
      bit acc = 1'b0;
      int tries = 0;
      while (!acc && tries < 200) begin
         try_send(d, s, last, acc);
         tries++;
      end
      if (!acc) check("send_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain", exp_q.size(), 0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin : monitor
      fifo_entry_t e;
      #1;
      if (!rst && bus.o_valid && bus.o_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", bus.o_data, 0);
         end else begin
            e = exp_q.pop_front();
            check("o_data", bus.o_data, e.data);
            check("o_keep", bus.o_keep, e.keep);
            check("o_last", bus.o_last, e.last);
         end
         last_data = bus.o_data;
         last_keep = bus.o_keep;
         last_last = bus.o_last;
         n_pops++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit acc;
      int accepted;
      int first_rej;
      int pops0;
      int unsigned d, s;
      int tries;

      bus.i_valid = 1'b1;
      bus.i_data  = 21'd77;
      bus.i_shift = 4'd0;
      bus.i_last  = 1'b1;
      bus.o_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_i_ready", bus.i_ready, 1);
      check("rst_o_valid", bus.o_valid, 0);
      check("rst_o_data",  bus.o_data, 0);
      check("rst_o_keep",  bus.o_keep, 0);
      check("rst_o_last",  bus.o_last, 0);
      rst = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
      @(negedge clk);
      check("post_rst_o_valid", bus.o_valid, 0);
      check("post_rst_i_ready", bus.i_ready, 1);

      send(5, 2, 0);
      send(6, 2, 0);
      send(7, 2, 0);
      check("pre_word_o_valid", bus.o_valid, 0);
      send(10, 2, 0);
      check("latency_o_valid", bus.o_valid, 1);
      wait_drain();
      check("round_data", last_data, 32'h02020201);
      check("round_keep", last_keep, 4'hF);
      check("round_last", last_last, 0);

      send(300, 0, 0);
      send(21'h1FFFFF, 4, 1);
      wait_drain();
      check("sat_data", last_data, 32'h0000FFFF);
      check("sat_keep", last_keep, 4'b0011);
      check("sat_last", last_last, 1);
`ifdef ACT_PACKER_STATS_EN
      check("sat_cnt", sat_cnt, 2);
`endif

      send(1, 0, 0);
      send(2, 0, 0);
      send(3, 0, 1);
      wait_drain();
      check("flush_data", last_data, 32'h00030201);
      check("flush_keep", last_keep, 4'b0111);
      check("flush_last", last_last, 1);
      send(9, 0, 1);
      wait_drain();
      check("lane0_data", last_data, 32'h00000009);
      check("lane0_keep", last_keep, 4'b0001);

      bus.o_ready = 1'b0;
      accepted  = 0;
      first_rej = -1;
      pops0     = n_pops;
      for (int i = 0; i < 20; i++) begin
         try_send(i + 1, 0, 0, acc);
         if (acc) accepted++;
         else if (first_rej < 0) first_rej = i;
      end
      check("full_accepted", accepted, 16);
      check("full_first_reject", first_rej, 16);
      check("full_i_ready", bus.i_ready, 0);
      bus.o_ready = 1'b1;
      #1;
      check("full_i_ready_hold", bus.i_ready, 0);
      @(negedge clk);
      check("i_ready_after_pop", bus.i_ready, 1);
      for (int i = 16; i < 20; i++) send(i + 1, 0, 0);
      wait_drain();
      check("full_pops", n_pops - pops0, 5);
      check("full_last_word", last_data, 32'h14131211);

      send(50, 0, 0);
      send(60, 0, 0);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      check("midrst_o_valid", bus.o_valid, 0);
      check("midrst_i_ready", bus.i_ready, 1);
`ifdef ACT_PACKER_STATS_EN
      check("midrst_sat_cnt", sat_cnt, 0);
`endif
      send(11, 0, 0);
      send(12, 0, 0);
      send(13, 0, 0);
      send(14, 0, 0);
      wait_drain();
      check("clean_data", last_data, 32'h0E0D0C0B);
      check("clean_keep", last_keep, 4'hF);

      for (int n = 0; n < 80; n++) begin
         d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 21'h1FFFFF) : $urandom_range(0, 4095);
         s = $urandom_range(0, 15);
         acc = 1'b0;
         tries = 0;
         while (!acc && tries < 200) begin
            bus.o_ready = ($urandom_range(0, 2) != 0);
            try_send(d, s, ($urandom_range(0, 7) == 0), acc);
            tries++;
         end
         if (!acc) check("rand_send_timeout", 0, 1);
      end
      bus.o_ready = 1'b1;
      send(0, 0, 1);
      wait_drain();
      check("final_o_valid", bus.o_valid, 0);
`ifdef ACT_PACKER_STATS_EN
      check("final_sat_cnt", sat_cnt, m_sat);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
